// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch stage and its output buffer.
package fetch_unit_pkg;

  localparam int          FETCH_ADDR_W   = 16;
  localparam int          FETCH_DATA_W   = 32;
  localparam logic [15:0] FETCH_RESET_PC = 16'h0000;
  localparam int          INSTR_BYTES    = 4;

  typedef logic [1:0] fifo_cnt_t;

  localparam fifo_cnt_t FIFO_DEPTH = 2'd2;

endpackage

// File: rtl/fetch_unit_skid_fifo.sv
// Two-entry {pc,instr} buffer between the RAM read port and decode.
// The head entry is a register, so decode never sees a combinational path from the RAM.
module fetch_unit_skid_fifo
  import fetch_unit_pkg::*;
#(
  parameter int W = FETCH_ADDR_W + FETCH_DATA_W
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  logic [W-1:0]    push_data,
  input  logic            pop,
  output logic [W-1:0]    head,
  output fifo_cnt_t       cnt
);

  logic [W-1:0] tail;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt  <= '0;
      // NOTE: only the head is cleared because it drives the outputs; the tail is a
      // pure data register gated by cnt and needs no reset.
      head <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) head <= push_data;
          else             tail <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          // Simultaneous push and pop: occupancy is unchanged, entries shift forward.
          if (cnt == FIFO_DEPTH) begin
            head <= tail;
            tail <= push_data;
          end else begin
            head <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  // The issue rule upstream guarantees the buffer never overflows.
  always_ff @(posedge clock) begin
    if (!reset) assert (cnt <= FIFO_DEPTH);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the word RAM with the pc, captures its registered
// read data one cycle later and hands {pc,instr} to decode over valid/ready.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int               ADDR_W   = FETCH_ADDR_W,
  parameter int               DATA_W   = FETCH_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr
);

  localparam int ENTRY_W = ADDR_W + DATA_W;

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  inflight_pc;
  logic               inflight;
  fifo_cnt_t          cnt;
  logic [ENTRY_W-1:0] head;
  logic [2:0]         occupancy;
  logic               deq;
  logic               issue;
  logic               push;
  logic               unused_redirect_lsbs;

  assign mem_we = 1'b0;
  assign mem_d  = '0;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    mem_addr = pc;
    if (redirect_valid) mem_addr = {redirect_pc[ADDR_W-1:2], 2'b00};
  end

  assign out_valid = (cnt != 2'd0) && !redirect_valid;
  assign deq       = out_valid && out_ready;

  // Words owned by the stage (buffered + in flight) after this cycle's dequeue must stay below 2.
  assign occupancy = {1'b0, cnt} + {2'b00, inflight};
  assign issue     = !reset && (redirect_valid || (occupancy < (3'd2 + {2'b00, deq})));

  // A redirect kills the word returning this cycle.
  assign push = inflight && !redirect_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc       <= RESET_PC;
      inflight <= 1'b0;
    end else if (issue) begin
      pc          <= mem_addr + ADDR_W'(INSTR_BYTES);
      inflight    <= 1'b1;
      inflight_pc <= mem_addr;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_unit_skid_fifo #(
    .W (ENTRY_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({inflight_pc, mem_q}),
    .pop       (deq),
    .head      (head),
    .cnt       (cnt)
  );

  assign out_pc    = head[ENTRY_W-1:DATA_W];
  assign out_instr = head[DATA_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit wired to a preloaded word RAM model.
// A stream model predicts every accepted {pc,instr} from the last reset/redirect target.
module tb_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_d;
  logic [31:0] mem_q;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc    = '0;
  logic        out_valid;
  logic        out_ready      = 1'b1;
  logic [15:0] out_pc;
  logic [31:0] out_instr;

  int n_checks   = 0;
  int n_errors   = 0;
  int n_accepted = 0;

  logic [15:0] exp_pc = RESET_PC;
  logic        hold_pending = 1'b0;
  logic [15:0] held_pc;
  logic [31:0] held_instr;

  fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_d          (mem_d),
    .mem_q          (mem_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ram_word(input logic [15:0] a);
    return 32'h1000_0000 + {18'd0, a[15:2]};
  endfunction

  // Word RAM with registered read, preloaded with word i = 0x1000_0000 + i.
  always @(posedge clock) mem_q <= ram_word(mem_addr);

  // One cycle: score the current cycle against the stream model, then advance to the next negedge.
  task automatic tick();
    #1;
    if (redirect_valid) begin
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL redirect_blocks_valid: out_valid=%b required 0", out_valid);
      end
    end
    if (hold_pending && !redirect_valid) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== held_pc || out_instr !== held_instr) begin
        n_errors++;
        $display("FAIL hold_stable: valid=%b pc=%h instr=%h required 1 %h %h",
                 out_valid, out_pc, out_instr, held_pc, held_instr);
      end
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_checks++;
      if (out_pc !== exp_pc || out_instr !== ram_word(exp_pc)) begin
        n_errors++;
        $display("FAIL stream_order: pc=%h instr=%h required %h %h",
                 out_pc, out_instr, exp_pc, ram_word(exp_pc));
      end
      exp_pc = exp_pc + 16'd4;
      n_accepted++;
    end
    hold_pending = (out_valid === 1'b1) && !out_ready && !redirect_valid && !reset;
    held_pc      = out_pc;
    held_instr   = out_instr;
    if (reset)               exp_pc = RESET_PC;
    else if (redirect_valid) exp_pc = redirect_pc & 16'hFFFC;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic expect_out(input string name, input logic valid, input logic [15:0] pc,
                            input logic check_data);
    #1;
    n_checks++;
    if (out_valid !== valid || (check_data && (out_pc !== pc || out_instr !== ram_word(pc)))) begin
      n_errors++;
      $display("FAIL %s: valid=%b pc=%h instr=%h required %b %h %h",
               name, out_valid, out_pc, out_instr, valid, pc, ram_word(pc));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_pc !== 16'h0 || out_instr !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: valid=%b pc=%h instr=%h required 0 0000 00000000",
               out_valid, out_pc, out_instr);
    end
    n_checks++;
    if (mem_addr !== RESET_PC || mem_we !== 1'b0 || mem_d !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_mem_port: addr=%h we=%b d=%h required %h 0 00000000",
               mem_addr, mem_we, mem_d, RESET_PC);
    end
    tick();
    expect_out("reset_latency_n1", 1'b0, 16'h0, 1'b0);
    tick();
    expect_out("reset_latency_n2", 1'b1, RESET_PC, 1'b1);
  endtask

  task automatic test_stream();
    for (int i = 0; i < 12; i++) begin
      expect_out("stream_no_gap", 1'b1, RESET_PC + 16'(4 * i), 1'b1);
      tick();
    end
  endtask

  task automatic test_backpressure();
    bit found = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (out_valid === 1'b1 && out_pc === 16'h0008) found = 1'b1;
      else tick();
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL bp_find_head: head pc 0008 not seen within 20 cycles, last pc=%h", out_pc);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_out("bp_hold", 1'b1, 16'h0008, 1'b1);
      n_checks++;
      if (mem_addr !== 16'h0010) begin
        n_errors++;
        $display("FAIL bp_stall_addr: mem_addr=%h required 0010", mem_addr);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_out("bp_release", 1'b1, 16'h0008 + 16'(4 * i), 1'b1);
      tick();
    end
  endtask

  task automatic test_redirect();
    out_ready = 1'b0;
    repeat (2) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    #1;
    n_checks++;
    if (mem_addr !== 16'h0040) begin
      n_errors++;
      $display("FAIL redirect_addr: mem_addr=%h required 0040", mem_addr);
    end
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    expect_out("redirect_latency_n1", 1'b0, 16'h0, 1'b0);
    tick();
    expect_out("redirect_first", 1'b1, 16'h0040, 1'b1);
    repeat (6) tick();
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFF8;
    tick();
    redirect_valid = 1'b0;
    expect_out("wrap_latency_n1", 1'b0, 16'h0, 1'b0);
    tick();
    expect_out("wrap_fff8", 1'b1, 16'hFFF8, 1'b1);
    tick();
    expect_out("wrap_fffc", 1'b1, 16'hFFFC, 1'b1);
    tick();
    expect_out("wrap_0000", 1'b1, 16'h0000, 1'b1);
    tick();
  endtask

  task automatic test_redirect_on_handshake();
    expect_out("rdh_pre_valid", 1'b1, exp_pc, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0043;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || mem_addr !== 16'h0040) begin
      n_errors++;
      $display("FAIL rdh_same_cycle: valid=%b addr=%h required 0 0040", out_valid, mem_addr);
    end
    tick();
    redirect_valid = 1'b0;
    tick();
    expect_out("rdh_aligned_out", 1'b1, 16'h0040, 1'b1);
    repeat (3) tick();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    tick();
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();
    reset = 1'b0;
    expect_out("mid_reset_n0", 1'b0, 16'h0, 1'b0);
    tick();
    expect_out("mid_reset_n1", 1'b0, 16'h0, 1'b0);
    tick();
    expect_out("mid_reset_restart", 1'b1, RESET_PC, 1'b1);
    repeat (4) tick();
  endtask

  task automatic test_random();
    int start = n_accepted;
    for (int i = 0; i < 600; i++) begin
      int r = $urandom_range(0, 99);
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = (r < 4);
      redirect_pc    = 16'($urandom);
      reset          = (r == 4);
      tick();
    end
    redirect_valid = 1'b0;
    reset          = 1'b0;
    out_ready      = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (n_accepted - start < 100) begin
      n_errors++;
      $display("FAIL random_progress: accepted=%0d required >= 100", n_accepted - start);
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_redirect_on_handshake();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
